// File: rtl/hand_rr_arbiter.sv
// hand_rr_arbiter: packet-level round-robin scheduler sharing one valid/ready stream among CHL channels
module hand_rr_arbiter #(
    parameter int CHL = 2,
    parameter int DW  = 8,
    parameter int CW  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CHL-1:0]    s_valid,
    output logic [CHL-1:0]    s_ready,
    input  logic [CHL*DW-1:0] s_data,
    input  logic [CHL-1:0]    s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_data,
    output logic              m_last,
    output logic [CHL-1:0]    grant,
    output logic [CW-1:0]     pkt_cnt
);
    localparam int PW = $clog2(CHL);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state, state_nxt;
    logic [CHL-1:0] grant_nxt;
    logic [PW-1:0]  owner, owner_nxt, rr_ptr, sel, idx;
    logic           found, busy, xfer, done;

    assign busy = state == BUSY;
    assign xfer = busy && s_valid[owner] && m_ready;
    assign done = xfer && s_last[owner];

    // first requester after the last completed owner, wrapping around
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= CHL; k++) begin
            idx = PW'((int'(rr_ptr) + k) % CHL);
            if (!found && s_valid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // state, ownership, fairness pointer and completed-packet counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= '0;
            owner   <= '0;
            rr_ptr  <= PW'(CHL - 1);
            pkt_cnt <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            owner <= owner_nxt;
            if (done) begin
                rr_ptr  <= owner;
                pkt_cnt <= pkt_cnt + CW'(1);
            end
        end
    end

    // arbitrate only when idle; release only on a last-beat handshake
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        owner_nxt = owner;
        if (!busy && found) begin
            state_nxt = BUSY;
            grant_nxt = CHL'(1) << sel;
            owner_nxt = sel;
        end else if (done) begin
            state_nxt = IDLE;
            grant_nxt = '0;
        end
    end

    // owner's channel is wired straight through; everything quiet when idle
    always_comb begin
        m_valid = busy && s_valid[owner];
        m_data  = busy ? s_data[int'(owner)*DW +: DW] : '0;
        m_last  = busy && s_last[owner];
        s_ready = busy ? grant & {CHL{m_ready}} : '0;
    end
endmodule

// File: tb/tb_hand_rr_arbiter.sv
// tb_hand_rr_arbiter: scoreboard bench for the packet round-robin arbiter
module tb_hand_rr_arbiter;
    localparam int CHL = 2;
    localparam int DW  = 8;
    localparam int CW  = 4;

    typedef struct packed {logic [7:0] d; logic l;} src_t;
    typedef struct packed {logic [1:0] g; logic [7:0] d; logic l;} exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CHL-1:0]    s_valid = '0;
    logic [CHL-1:0]    s_ready;
    logic [CHL*DW-1:0] s_data = '0;
    logic [CHL-1:0]    s_last = '0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [DW-1:0]     m_data;
    logic              m_last;
    logic [CHL-1:0]    grant;
    logic [CW-1:0]     pkt_cnt;

    src_t       q0[$];
    src_t       q1[$];
    exp_t       sb[$];
    logic [1:0] en = 2'b11;
    int         total = 0;
    int         passed = 0;
    int         xfers = 0;

    hand_rr_arbiter #(.CHL(CHL), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .grant(grant), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted, required normal completion");
        $fatal(1, "watchdog");
    end

    // every output handshake must match the next expected beat
    always @(negedge clk) begin
        exp_t e;
        if (!rst && m_valid && m_ready) begin
            total++;
            if (sb.size() == 0)
                $display("FAIL beat_unexpected: grant=%b data=%h last=%b, required no beat", grant, m_data, m_last);
            else begin
                e = sb.pop_front();
                if ({grant, m_data, m_last} !== {e.g, e.d, e.l})
                    $display("FAIL beat: grant=%b data=%h last=%b, required grant=%b data=%h last=%b",
                             grant, m_data, m_last, e.g, e.d, e.l);
                else passed++;
            end
        end
    end

    // queue a source beat and its expected output (tests enqueue in expected output order)
    task automatic pkt(input int ch, input logic [7:0] d, input logic l);
        if (ch == 0) q0.push_back({d, l});
        else q1.push_back({d, l});
        sb.push_back({(ch == 0) ? 2'b01 : 2'b10, d, l});
    endtask

    task automatic drive();
        s_valid = {en[1] && q1.size() > 0, en[0] && q0.size() > 0};
        s_data  = {q1.size() > 0 ? q1[0].d : 8'h00, q0.size() > 0 ? q0[0].d : 8'h00};
        s_last  = {q1.size() > 0 ? q1[0].l : 1'b0, q0.size() > 0 ? q0[0].l : 1'b0};
    endtask

    task automatic step();
        logic [1:0] hs;
        @(posedge clk);
        hs = s_valid & s_ready;
        #1;
        if (hs[0]) void'(q0.pop_front());
        if (hs[1]) void'(q1.pop_front());
        xfers += int'(hs[0]) + int'(hs[1]);
        drive();
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || grant !== 2'b00) && n < max) begin
            step();
            n++;
        end
        total++;
        if (n >= max) $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
        else passed++;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({grant, m_valid, s_ready, m_data, m_last, pkt_cnt} !== '0)
            $display("FAIL reset_outputs: grant=%b m_valid=%b s_ready=%b m_data=%h m_last=%b pkt_cnt=%0d, required all 0",
                     grant, m_valid, s_ready, m_data, m_last, pkt_cnt);
        else passed++;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_single_ch1();
        pkt(1, 8'h11, 1'b0);
        pkt(1, 8'h12, 1'b0);
        pkt(1, 8'h13, 1'b1);
        drive();
        step();
        total++;
        if (grant !== 2'b10) $display("FAIL ch1_grant: grant=%b, required 10", grant); else passed++;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if ({m_valid, grant} !== 3'b110) $display("FAIL ch1_streaming: m_valid=%b grant=%b, required 1/10", m_valid, grant);
            else passed++;
        end
        step();
        total++;
        if ({grant, m_data, m_valid} !== '0) $display("FAIL ch1_release: grant=%b m_data=%h m_valid=%b, required 0", grant, m_data, m_valid);
        else passed++;
        total++;
        if (pkt_cnt !== 4'd1) $display("FAIL ch1_pkt_cnt: pkt_cnt=%0d, required 1", pkt_cnt); else passed++;
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 4; i++) begin
            pkt(0, 8'hA0 + 8'(i), 1'b1);
            pkt(1, 8'hB0 + 8'(i), 1'b1);
        end
        drive();
        xfers = 0;
        for (int i = 0; i < 8; i++) step();
        total++;
        if (xfers != 4) $display("FAIL alt_rate: %0d transfers in 8 cycles, required 4", xfers); else passed++;
        total++;
        if (pkt_cnt !== 4'd5) $display("FAIL alt_pkt_cnt_mid: pkt_cnt=%0d, required 5", pkt_cnt); else passed++;
        wait_idle(40);
        total++;
        if (pkt_cnt !== 4'd9) $display("FAIL alt_pkt_cnt: pkt_cnt=%0d, required 9", pkt_cnt); else passed++;
    endtask

    task automatic test_backpressure();
        pkt(0, 8'hC0, 1'b0);
        pkt(0, 8'hC1, 1'b1);
        pkt(1, 8'hD0, 1'b1);
        drive();
        step();
        step();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if ({s_ready, m_valid, m_data, grant} !== {2'b00, 1'b1, 8'hC1, 2'b01})
                $display("FAIL bp_hold: s_ready=%b m_valid=%b m_data=%h grant=%b, required 00/1/c1/01", s_ready, m_valid, m_data, grant);
            else passed++;
        end
        m_ready = 1'b1;
        wait_idle(20);
        total++;
        if (pkt_cnt !== 4'd11) $display("FAIL bp_pkt_cnt: pkt_cnt=%0d, required 11", pkt_cnt); else passed++;
    endtask

    task automatic test_bubble();
        pkt(0, 8'hE0, 1'b0);
        pkt(0, 8'hE1, 1'b1);
        pkt(1, 8'hF0, 1'b1);
        drive();
        step();
        step();
        en = 2'b10;
        drive();
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({grant, m_valid, s_ready[1]} !== {2'b01, 1'b0, 1'b0})
                $display("FAIL bubble_hold: grant=%b m_valid=%b s_ready1=%b, required 01/0/0", grant, m_valid, s_ready[1]);
            else passed++;
        end
        en = 2'b11;
        drive();
        wait_idle(20);
        total++;
        if (pkt_cnt !== 4'd13) $display("FAIL bubble_pkt_cnt: pkt_cnt=%0d, required 13", pkt_cnt); else passed++;
    endtask

    task automatic test_reset_mid();
        pkt(1, 8'h21, 1'b0);
        pkt(1, 8'h22, 1'b0);
        pkt(1, 8'h23, 1'b1);
        drive();
        step();
        step();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({grant, m_valid, s_ready, pkt_cnt} !== '0)
            $display("FAIL rst_mid: grant=%b m_valid=%b s_ready=%b pkt_cnt=%0d, required all 0", grant, m_valid, s_ready, pkt_cnt);
        else passed++;
        total++;
        if (sb.size() != 2) $display("FAIL rst_mid_pending: %0d beats pending, required 2", sb.size()); else passed++;
        q1.delete();
        sb.delete();
        pkt(0, 8'h30, 1'b1);
        pkt(1, 8'h31, 1'b1);
        @(negedge clk) rst = 1'b0;
        drive();
        step();
        total++;
        if (grant !== 2'b01) $display("FAIL rst_mid_first: grant=%b, required 01", grant); else passed++;
        wait_idle(20);
        total++;
        if (pkt_cnt !== 4'd2) $display("FAIL rst_mid_pkt_cnt: pkt_cnt=%0d, required 2", pkt_cnt); else passed++;
    endtask

    task automatic test_wrap();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 15; i++) pkt(0, 8'h40 + 8'(i), 1'b1);
        drive();
        wait_idle(100);
        total++;
        if (pkt_cnt !== 4'd15) $display("FAIL wrap_15: pkt_cnt=%0d, required 15", pkt_cnt); else passed++;
        pkt(0, 8'h4F, 1'b1);
        drive();
        wait_idle(20);
        total++;
        if (pkt_cnt !== 4'd0) $display("FAIL wrap_16: pkt_cnt=%0d, required 0", pkt_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_ch1();
        test_alternate();
        test_backpressure();
        test_bubble();
        test_reset_mid();
        test_wrap();
        step();
        total++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d beats never seen, required 0", sb.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
